// File: rtl/slave_split_if_pkg.sv
// Shared definitions for the per-slave split handshake (slave side and bus controller).
package slave_split_if_pkg;

    localparam int MID_W = 4;
    localparam logic [MID_W-1:0] MID_NONE = 4'b1111;

    typedef enum logic [2:0] {
        IDLE,
        BUSY,
        GUARD,
        WAIT_ACK,
        ACK
    } split_state_t;

endpackage

// File: rtl/slave_split_if_if.sv
// Core-side signal bundle of the split handshake; timeout_err exists only with SPLIT_TIMEOUT_EN.
interface slave_split_if_if;

    logic                                 split_req;
    logic [slave_split_if_pkg::MID_W-1:0] req_mid;
    logic                                 work_done;
    logic                                 split_active;
    logic                                 resume;
    logic [slave_split_if_pkg::MID_W-1:0] resume_mid;
`ifdef SPLIT_TIMEOUT_EN
    logic                                 timeout_err;

    modport slave  (input  split_req, req_mid, work_done,
                    output split_active, resume, resume_mid, timeout_err);
    modport master (output split_req, req_mid, work_done,
                    input  split_active, resume, resume_mid, timeout_err);
`else
    modport slave  (input  split_req, req_mid, work_done,
                    output split_active, resume, resume_mid);
    modport master (output split_req, req_mid, work_done,
                    input  split_active, resume, resume_mid);
`endif

endinterface

// File: rtl/slave_split_if_od_line.sv
// Open-drain pad for the split handshake line: pulls low or floats, and reports the line level.
module od_line (
    input  logic drive_low,
    inout  wire  line,
    output logic level
);

    assign line  = drive_low ? 1'b0 : 1'bz;
    assign level = line;

endmodule

// File: rtl/slave_split_if.sv
// Slave end of the split handshake: hold line low while busy, release, await controller ack pulse.
// Optional macro SPLIT_TIMEOUT_EN adds an ack-wait timeout with a timeout_err pulse.
module slave_split_if
    import slave_split_if_pkg::*;
#(
    parameter int MIN_LOW_CYCLES = 2,
    parameter int GUARD_CYCLES   = 2,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                   clk,
    input  logic                   rst,
    slave_split_if_if.slave        bus,
    inout  wire                    split_line
);

    localparam int CNT_MAX_A = (MIN_LOW_CYCLES > GUARD_CYCLES) ? MIN_LOW_CYCLES : GUARD_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > TIMEOUT_CYCLES) ? CNT_MAX_A : TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    split_state_t     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             drive_q, drive_d;
    logic             active_q, active_d;
    logic             resume_q, resume_d;
    logic [MID_W-1:0] mid_q, mid_d;
    logic             line_lvl;
    logic             line_low;
    logic             low_done;
    logic             guard_done;
`ifdef SPLIT_TIMEOUT_EN
    logic             tout_q, tout_d;
    logic             tout_hit;

    assign tout_hit        = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));
    assign bus.timeout_err = tout_q;
`endif

    od_line u_pad (
        .drive_low (drive_q),
        .line      (split_line),
        .level     (line_lvl)
    );

    // Only consulted in WAIT_ACK/ACK, where our own driver is off.
    assign line_low   = (line_lvl == 1'b0);
    assign low_done   = (cnt_q >= CNT_W'(MIN_LOW_CYCLES - 1));
    assign guard_done = (cnt_q >= CNT_W'(GUARD_CYCLES - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            drive_q  <= 1'b0;
            active_q <= 1'b0;
            resume_q <= 1'b0;
            mid_q    <= MID_NONE;
`ifdef SPLIT_TIMEOUT_EN
            tout_q   <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            drive_q  <= drive_d;
            active_q <= active_d;
            resume_q <= resume_d;
            mid_q    <= mid_d;
`ifdef SPLIT_TIMEOUT_EN
            tout_q   <= tout_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (bus.split_req) state_d = BUSY;
            BUSY:     if (low_done && bus.work_done) state_d = GUARD;
            GUARD:    if (guard_done) state_d = WAIT_ACK;
            WAIT_ACK: begin
                // An ack on the same edge as the timeout takes precedence.
                if (line_low) state_d = ACK;
`ifdef SPLIT_TIMEOUT_EN
                else if (tout_hit) state_d = IDLE;
`endif
            end
            ACK:      if (!line_low) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_comb begin
        drive_d  = (state_d == BUSY);
        active_d = (state_d != IDLE);
        resume_d = (state_q == WAIT_ACK) && (state_d == ACK);
        mid_d    = mid_q;
        if ((state_q == IDLE) && (state_d == BUSY))
            mid_d = bus.req_mid;
        else if (state_d == IDLE)
            mid_d = MID_NONE;
        if (state_d != state_q)
            cnt_d = '0;
        else
            cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
`ifdef SPLIT_TIMEOUT_EN
        tout_d   = (state_q == WAIT_ACK) && (state_d == IDLE);
`endif
    end

    assign bus.split_active = active_q;
    assign bus.resume       = resume_q;
    assign bus.resume_mid   = mid_q;

endmodule

// File: tb/tb_slave_split_if.sv
// Bench for slave_split_if: timeline-based reference model of the split handshake.
`timescale 1ns/1ps
module tb_slave_split_if;
    import slave_split_if_pkg::*;

    localparam int MIN_LOW = 2;
    localparam int GUARD   = 2;
`ifdef SPLIT_TIMEOUT_EN
    localparam int TOUT    = 8;
`else
    localparam int TOUT    = 255;
`endif

    logic clk = 1'b0;
    logic rst;
    logic ctrl_low;
    wire  split_line;
    int   n_vec = 0;
    int   n_err = 0;

    pullup (split_line);
    assign split_line = ctrl_low ? 1'b0 : 1'bz;

    slave_split_if_if bus ();

    slave_split_if #(
        .MIN_LOW_CYCLES (MIN_LOW),
        .GUARD_CYCLES   (GUARD),
        .TIMEOUT_CYCLES (TOUT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .split_line (split_line)
    );

    always #5 clk = ~clk;

    // One split transaction. Edge 0 samples split_req; interval c is the time after edge c.
    // Release edge R = max(MIN_LOW, first edge work_done is seen); ack sampled at M = R+GUARD+ack_dly.
    task automatic run_txn(input string name, input int wd_at, input int ack_dly,
                           input int noise_g, input logic [3:0] mid, input bit hold);
        int   r_edge, m_edge, noise_at;
        logic exp_line, exp_act, exp_res;
        logic [3:0] exp_mid;
        r_edge   = (wd_at > MIN_LOW) ? wd_at : MIN_LOW;
        m_edge   = r_edge + GUARD + ack_dly;
        noise_at = (noise_g > 0) ? r_edge + noise_g : -1;
        bus.split_req = 1'b1;
        bus.req_mid   = mid;
        bus.work_done = (wd_at == 0);
        for (int c = 0; c <= m_edge + 1; c++) begin
            @(posedge clk);
            @(negedge clk);
            exp_line = !((c <= r_edge - 1) || ctrl_low);
            exp_act  = (c <= m_edge);
            exp_res  = (c == m_edge);
            exp_mid  = (c <= m_edge) ? mid : MID_NONE;
            n_vec++;
            if (split_line !== exp_line) begin
                n_err++;
                $display("FAIL %s line c=%0d got=%b exp=%b", name, c, split_line, exp_line);
            end
            n_vec++;
            if (bus.split_active !== exp_act) begin
                n_err++;
                $display("FAIL %s split_active c=%0d got=%b exp=%b", name, c, bus.split_active, exp_act);
            end
            n_vec++;
            if (bus.resume !== exp_res) begin
                n_err++;
                $display("FAIL %s resume c=%0d got=%b exp=%b", name, c, bus.resume, exp_res);
            end
            n_vec++;
            if (bus.resume_mid !== exp_mid) begin
                n_err++;
                $display("FAIL %s resume_mid c=%0d got=%h exp=%h", name, c, bus.resume_mid, exp_mid);
            end
`ifdef SPLIT_TIMEOUT_EN
            n_vec++;
            if (bus.timeout_err !== 1'b0) begin
                n_err++;
                $display("FAIL %s timeout_err c=%0d got=%b exp=0", name, c, bus.timeout_err);
            end
`endif
            bus.split_req = hold;
            bus.req_mid   = 4'($urandom_range(0, 15));
            bus.work_done = (c + 1 >= wd_at) && (c + 1 <= r_edge);
            ctrl_low      = (c + 1 == m_edge) || (c + 1 == noise_at);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ctrl_low = 1'b0;
        bus.split_req = 1'b1;
        bus.req_mid   = 4'd3;
        bus.work_done = 1'b0;
        repeat (3) @(negedge clk);
        n_vec++;
        if (split_line !== 1'b1 || bus.split_active !== 1'b0 || bus.resume !== 1'b0) begin
            n_err++;
            $display("FAIL reset_state line=%b act=%b res=%b exp=1/0/0", split_line, bus.split_active, bus.resume);
        end
        n_vec++;
        if (bus.resume_mid !== MID_NONE) begin
            n_err++;
            $display("FAIL reset_mid got=%h exp=%h", bus.resume_mid, MID_NONE);
        end
        bus.split_req = 1'b0;
        rst = 1'b0;
        @(posedge clk);
        @(negedge clk);
        n_vec++;
        if (bus.split_active !== 1'b0 || split_line !== 1'b1) begin
            n_err++;
            $display("FAIL idle_after_reset act=%b line=%b exp=0/1", bus.split_active, split_line);
        end
    endtask

    task automatic test_basic();
        run_txn("basic", 10, 1, 0, 4'd5, 1'b0);
    endtask

    task automatic test_early_done();
        run_txn("early_done", 0, 1, 0, 4'd9, 1'b0);
        run_txn("done_at_1", 1, 3, 0, 4'd2, 1'b0);
    endtask

    task automatic test_guard();
        for (int g = 1; g <= GUARD; g++)
            run_txn("guard_noise", 3, 2, g, 4'($urandom_range(0, 14)), 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            run_txn("random", int'($urandom_range(0, 7)), int'($urandom_range(1, 6)),
                    int'($urandom_range(0, GUARD)), 4'($urandom_range(0, 14)), 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_first", 4, 2, 0, 4'd7, 1'b1);
        run_txn("b2b_second", 0, 1, 0, 4'd1, 1'b0);
    endtask

    task automatic test_reset_mid();
        int k;
        for (int i = 0; i < 5; i++) begin
            k = int'($urandom_range(0, MIN_LOW + GUARD + 3));
            bus.split_req = 1'b1;
            bus.req_mid   = 4'd6;
            bus.work_done = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.split_req = 1'b0;
            repeat (k) @(negedge clk);
            #2 rst = 1'b1;
            #1;
            n_vec++;
            if (split_line !== 1'b1) begin
                n_err++;
                $display("FAIL rst_mid_line k=%0d got=%b exp=1", k, split_line);
            end
            n_vec++;
            if (bus.split_active !== 1'b0 || bus.resume !== 1'b0 || bus.resume_mid !== MID_NONE) begin
                n_err++;
                $display("FAIL rst_mid_outputs k=%0d act=%b res=%b mid=%h exp=0/0/f", k, bus.split_active, bus.resume, bus.resume_mid);
            end
            bus.work_done = 1'b0;
            @(negedge clk);
            rst = 1'b0;
            @(posedge clk);
            @(negedge clk);
            n_vec++;
            if (bus.split_active !== 1'b0) begin
                n_err++;
                $display("FAIL rst_mid_idle k=%0d act=%b exp=0", k, bus.split_active);
            end
        end
    endtask

`ifdef SPLIT_TIMEOUT_EN
    task automatic test_timeout();
        int w_edge;
        logic exp_act;
        w_edge = MIN_LOW + GUARD;
        bus.split_req = 1'b1;
        bus.req_mid   = 4'd4;
        bus.work_done = 1'b1;
        for (int c = 0; c <= w_edge + TOUT + 2; c++) begin
            @(posedge clk);
            @(negedge clk);
            bus.split_req = 1'b0;
            exp_act = (c <= w_edge + TOUT - 1);
            n_vec++;
            if (bus.timeout_err !== (c == w_edge + TOUT)) begin
                n_err++;
                $display("FAIL timeout_err c=%0d got=%b exp=%b", c, bus.timeout_err, (c == w_edge + TOUT));
            end
            n_vec++;
            if (bus.split_active !== exp_act || bus.resume !== 1'b0) begin
                n_err++;
                $display("FAIL timeout_state c=%0d act=%b res=%b exp=%b/0", c, bus.split_active, bus.resume, exp_act);
            end
        end
        bus.work_done = 1'b0;
        run_txn("ack_at_timeout", MIN_LOW, TOUT, 0, 4'd8, 1'b0);
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_early_done();
        test_guard();
        test_random();
        test_back_to_back();
        test_reset_mid();
`ifdef SPLIT_TIMEOUT_EN
        test_timeout();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
